// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between board request sources and the round-robin mux arbiter.
interface mux_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       valid;

   modport master (output req, input grant, input sel, input valid);
   modport slave  (input req, output grant, output sel, output valid);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4-to-1 mux select from a registered one-hot grant.
// Optional timeout preemption of contested grants is compiled in with MUX_ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no grant, valid=0, sel keeps last granted index
// S_GRANT | one grant bit set, valid=1, hold_cnt counting grant age
module mux_rr_arbiter #(
   parameter int HOLD_CYCLES = 4,
   parameter int QUANTUM     = 16,
   parameter int CNT_W       = 5
) (
   input  logic             Clock,
   input  logic             Resetn,
   mux_rr_arbiter_if.slave  bus
);

`ifdef MUX_ARB_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [3:0]       others;
   logic [3:0]       search;
   logic             do_issue;
   logic             do_release;
   logic             do_preempt;
   logic [1:0]       pick;

   // First set bit of r scanning upward from p, wrapping modulo 4.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      idx   = p;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!found && r[p + 2'(k)]) begin
            idx   = p + 2'(k);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      others     = bus.req & ~grant_q;
      search     = 4'b0000;
      do_issue   = 1'b0;
      do_release = 1'b0;
      do_preempt = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               search   = bus.req;
               do_issue = 1'b1;
            end
         end
         S_GRANT: begin
            do_release = !(|(bus.req & grant_q)) && (hold_cnt_q >= CNT_W'(HOLD_CYCLES));
            do_preempt = TIMEOUT_EN && (hold_cnt_q >= CNT_W'(QUANTUM)) && (|others);
            if (do_release || do_preempt) begin
               if (|others) begin
                  // Hand over directly so grant never passes through zero.
                  search   = others;
                  do_issue = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  grant_d = 4'b0000;
               end
            end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pick = rr_pick(search, ptr_q);
      if (do_issue) begin
         state_d    = S_GRANT;
         grant_d    = 4'b0001 << pick;
         sel_d      = pick;
         ptr_d      = pick + 2'd1;
         hold_cnt_d = CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_IDLE;
         grant_q    <= 4'b0000;
         sel_q      <= 2'b00;
         ptr_q      <= 2'b00;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.sel   = sel_q;
   assign bus.valid = (state_q == S_GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter against an index-based round-robin reference model.
module tb_mux_rr_arbiter;
   localparam int HOLD    = 4;
   localparam int QUANTUM = 16;
   localparam int SAT     = 31;
`ifdef MUX_ARB_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   // Reference model: granted index (-1 = idle), search pointer, grant age, last select.
   int m_g, m_ptr, m_cnt, m_sel;

   mux_rr_arbiter_if bus ();

   mux_rr_arbiter #(.HOLD_CYCLES(HOLD), .QUANTUM(QUANTUM), .CNT_W(5)) dut (
      .Clock  (clk),
      .Resetn (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic void model_reset();
      m_g   = -1;
      m_ptr = 0;
      m_cnt = 0;
      m_sel = 0;
   endfunction

   function automatic void model_grant(input int g);
      m_g   = g;
      m_ptr = (g + 1) % 4;
      m_cnt = 1;
      m_sel = g;
   endfunction

   function automatic void model_step(input logic [3:0] r);
      logic [3:0] others;
      if (m_g < 0) begin
         if (r != 4'b0000) model_grant(pick(r, m_ptr));
      end else begin
         others = r & ~(4'b0001 << m_g);
         if ((!r[m_g] && m_cnt >= HOLD) || (TO && m_cnt >= QUANTUM && others != 4'b0000)) begin
            if (others != 4'b0000) model_grant(pick(others, m_ptr));
            else m_g = -1;
         end else if (m_cnt < SAT) begin
            m_cnt++;
         end
      end
   endfunction

   function automatic logic [3:0] m_grant();
      return (m_g < 0) ? 4'b0000 : (4'b0001 << m_g);
   endfunction

   task automatic cycle(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && m_g >= 0; i++) cycle(4'b0000);
      n_checks++;
      if (bus.valid !== 1'b0 || m_g >= 0) begin
         n_fail++;
         $display("FAIL drain: valid=%b model_idx=%0d required idle", bus.valid, m_g);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      bus.req = 4'b1111;
      model_reset();
      #2;
      n_checks++;
      if (bus.grant !== 4'b0000 || bus.sel !== 2'b00 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: grant=%b sel=%0d valid=%b required 0000/0/0", bus.grant, bus.sel, bus.valid);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rotation();
      int         seq[$];
      int         lens[$];
      logic [3:0] r;
      int         expect_seq[5] = '{0, 1, 2, 3, 0};
      r = 4'b1111;
      for (int t = 0; t < 20; t++) begin
         cycle(r);
         n_checks++;
         if (bus.grant !== m_grant() || bus.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rotation t=%0d: grant=%b valid=%b required %b/1", t, bus.grant, bus.valid, m_grant());
         end
         if (seq.size() == 0 || seq[$] != int'(bus.sel)) begin
            seq.push_back(int'(bus.sel));
            lens.push_back(1);
         end else begin
            lens[$] = lens[$] + 1;
         end
         r = 4'b1111 & ~((m_cnt >= HOLD) ? (4'b0001 << m_g) : 4'b0000);
      end
      n_checks++;
      if (seq.size() != 5) begin
         n_fail++;
         $display("FAIL rotation_count: grants=%0d required 5", seq.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (seq[i] != expect_seq[i] || lens[i] != HOLD) begin
               n_fail++;
               $display("FAIL rotation_seq[%0d]: idx=%0d len=%0d required idx=%0d len=%0d", i, seq[i], lens[i], expect_seq[i], HOLD);
            end
         end
      end
      drain();
   endtask

   task automatic test_pulse();
      for (int t = 0; t < 6; t++) begin
         cycle((t == 0) ? 4'b0100 : 4'b0000);
         n_checks++;
         if (t < HOLD) begin
            if (bus.grant !== 4'b0100 || bus.sel !== 2'd2 || bus.valid !== 1'b1) begin
               n_fail++;
               $display("FAIL pulse_hold t=%0d: grant=%b sel=%0d valid=%b required 0100/2/1", t, bus.grant, bus.sel, bus.valid);
            end
         end else if (bus.grant !== 4'b0000 || bus.sel !== 2'd2 || bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_idle t=%0d: grant=%b sel=%0d valid=%b required 0000/2/0", t, bus.grant, bus.sel, bus.valid);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] r;
      logic [3:0] want;
      for (int i = 0; i < 9; i++) begin
         r    = (i == 0) ? 4'b1000 : (i < 5) ? 4'b0001 : 4'b0110;
         want = (i < 4) ? 4'b1000 : (i < 8) ? 4'b0001 : 4'b0010;
         cycle(r);
         n_checks++;
         if (bus.grant !== want || bus.grant !== m_grant()) begin
            n_fail++;
            $display("FAIL wrap i=%0d: grant=%b required %b (model %b)", i, bus.grant, want, m_grant());
         end
      end
      drain();
   endtask

   task automatic test_timeout();
      logic [3:0] want;
      cycle(4'b0010);
      for (int t = 2; t <= 41; t++) begin
         cycle(4'b0110);
         want = (!TO || t <= QUANTUM || t > 2 * QUANTUM) ? 4'b0010 : 4'b0100;
         n_checks++;
         if (bus.grant !== want || bus.grant !== m_grant()) begin
            n_fail++;
            $display("FAIL timeout t=%0d: grant=%b required %b (model %b)", t, bus.grant, want, m_grant());
         end
      end
      drain();
   endtask

   task automatic test_async_reset();
      cycle(4'b0010);
      cycle(4'b0010);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (bus.grant !== 4'b0000 || bus.sel !== 2'b00 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: grant=%b sel=%0d valid=%b required 0000/0/0", bus.grant, bus.sel, bus.valid);
      end
      bus.req = 4'b1000;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(4'b1000);
      n_checks++;
      if (bus.grant !== 4'b1000 || bus.sel !== 2'd3 || bus.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: grant=%b sel=%0d valid=%b required 1000/3/1", bus.grant, bus.sel, bus.valid);
      end
      drain();
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic [3:0] prev;
      int         run;
      r    = 4'b0000;
      prev = 4'b0000;
      run  = 0;
      for (int t = 0; t < 1000; t++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         cycle(r);
         n_checks++;
         if (bus.grant !== m_grant() || bus.valid !== (m_g >= 0) || bus.sel !== 2'(m_sel)) begin
            n_fail++;
            $display("FAIL random_model t=%0d: grant=%b sel=%0d valid=%b required %b/%0d/%0b",
                     t, bus.grant, bus.sel, bus.valid, m_grant(), m_sel, (m_g >= 0));
         end
         n_checks++;
         if ($countones(bus.grant) > 1 || (bus.valid && bus.grant !== (4'b0001 << bus.sel))) begin
            n_fail++;
            $display("FAIL random_onehot t=%0d: grant=%b sel=%0d required one-hot matching sel", t, bus.grant, bus.sel);
         end
         if (bus.grant !== prev) begin
            if (prev != 4'b0000) begin
               n_checks++;
               if (run < HOLD) begin
                  n_fail++;
                  $display("FAIL random_minlen t=%0d: grant %b lasted %0d required >=%0d", t, prev, run, HOLD);
               end
            end
            run = 1;
         end else begin
            run++;
         end
         prev = bus.grant;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus.req  = 4'b0000;
      test_reset();
      test_rotation();
      test_pulse();
      test_wrap();
      test_timeout();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
